div_issue_ctrl: RTL

EX-stage issue and stall controller that sits directly upstream of the iterative divider `div`. It accepts a decoded divide/remainder instruction from the ID/EX register and drives the divider's operand/control inputs. It stalls the pipeline until `div_done` and returns a single-cycle writeback result. Divide-by-zero and signed-overflow cases are resolved locally without starting the divider.

---
 rtl/div_issue_ctrl_if.sv | 40 ++++
 rtl/div_issue_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/div_issue_ctrl_if.sv
// Bundle of pipeline-side and divider-side signals around the divide issue controller.
// master = the controller itself, slave = the pipeline/divider environment.
interface div_issue_ctrl_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            id_ex_valid;
  logic            id_ex_is_div;
  logic            id_ex_div_sign;
  logic            id_ex_div_res_sel;
  logic [XLEN-1:0] id_ex_rs1_data;
  logic [XLEN-1:0] id_ex_rs2_data;
  logic [RD_W-1:0] id_ex_rd;
  logic            flush;
  logic            ex_is_div_inst;
  logic            ex_div_sign;
  logic            ex_div_res_sel;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            div_done;
  logic [XLEN-1:0] div_res;
  logic            stall_req;
  logic            wb_valid;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    input  id_ex_valid, id_ex_is_div, id_ex_div_sign, id_ex_div_res_sel,
           id_ex_rs1_data, id_ex_rs2_data, id_ex_rd, flush, div_done, div_res,
    output ex_is_div_inst, ex_div_sign, ex_div_res_sel, dividend, divisor,
           stall_req, wb_valid, wb_rd, wb_data
  );

  modport slave (
    output id_ex_valid, id_ex_is_div, id_ex_div_sign, id_ex_div_res_sel,
           id_ex_rs1_data, id_ex_rs2_data, id_ex_rd, flush, div_done, div_res,
    input  ex_is_div_inst, ex_div_sign, ex_div_res_sel, dividend, divisor,
           stall_req, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage issue/stall controller for the iterative divider: launches a divide,
// stalls until div_done, resolves divide-by-zero and signed overflow locally.
module div_issue_ctrl #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  div_issue_ctrl_if.master   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state, state_nxt;
  logic            sign_q, res_sel_q;
  logic [XLEN-1:0] dividend_q, divisor_q, wb_data_q;
  logic [RD_W-1:0] rd_q;

  logic            accept;
  logic            div_by_zero, sign_ovf, special;
  logic [XLEN-1:0] special_res;

  assign accept = (state == S_IDLE) && bus.id_ex_valid && bus.id_ex_is_div && !bus.flush;

  // Results the divider would produce for the two corner cases, computed without running it.
  assign div_by_zero = (bus.id_ex_rs2_data == '0);
  assign sign_ovf    = bus.id_ex_div_sign && (bus.id_ex_rs1_data == MIN_NEG) &&
                       (bus.id_ex_rs2_data == '1);
  assign special     = div_by_zero || sign_ovf;
  assign special_res = bus.id_ex_div_res_sel ? (div_by_zero ? bus.id_ex_rs1_data : '0)
                                             : (div_by_zero ? '1 : MIN_NEG);

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = special ? S_DONE : S_BUSY;
      S_BUSY:  if (bus.flush) state_nxt = S_ABORT;
               else if (bus.div_done) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, since their reset values are visible on the ports.
    if (!rst_n) begin
      state      <= S_IDLE;
      sign_q     <= 1'b0;
      res_sel_q  <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rd_q       <= '0;
      wb_data_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sign_q     <= bus.id_ex_div_sign;
        res_sel_q  <= bus.id_ex_div_res_sel;
        dividend_q <= bus.id_ex_rs1_data;
        divisor_q  <= bus.id_ex_rs2_data;
        rd_q       <= bus.id_ex_rd;
      end
      if (accept && special)
        wb_data_q <= special_res;
      else if ((state == S_BUSY) && bus.div_done && !bus.flush)
        wb_data_q <= bus.div_res;
    end
  end

  // The request drops in ABORT and DONE, so the divider always sees a low cycle between operations.
  assign bus.ex_is_div_inst = (state == S_BUSY);
  assign bus.ex_div_sign    = sign_q;
  assign bus.ex_div_res_sel = res_sel_q;
  assign bus.dividend       = dividend_q;
  assign bus.divisor        = divisor_q;
  assign bus.stall_req      = !bus.flush && ((state == S_BUSY) || (state == S_ABORT) ||
                              ((state == S_IDLE) && bus.id_ex_valid && bus.id_ex_is_div));
  assign bus.wb_valid       = (state == S_DONE) && !bus.flush;
  assign bus.wb_rd          = rd_q;
  assign bus.wb_data        = wb_data_q;

endmodule
